// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake bundle for the sequential BCD-to-binary converter.
// The requester uses the master modport and the converter uses the slave modport.
interface bcd2bin_seq_if;
  logic        start;
  logic [23:0] bcd;
  logic [19:0] bin;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start,
    output bcd,
    input  bin,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  bcd,
    output bin,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Iterative 6-digit BCD to 20-bit binary converter (reverse double dabble).
// One bit per clock over 20 clocks. Non-decimal digits are flagged through err
// and force a zero result, but the full iteration count still runs so that
// latency never depends on the data.
module bcd2bin_seq (
  input  logic         clk,
  input  logic         rst,
  bcd2bin_seq_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [43:0] work_q, work_d;
  logic        bad_q, bad_d;
  logic [19:0] bin_q, bin_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [43:0] shifted;

  // One reverse-dabble step: shift right, then pull every BCD nibble that
  // reached 8 or more back down by 3. Each nibble is corrected on its own.
  function automatic logic [43:0] dabble_step(input logic [43:0] w);
    logic [43:0] s;
    s = w >> 1;
    for (int k = 0; k < 6; k++) begin
      if (s[20 + 4*k +: 4] >= 4'd8)
        s[20 + 4*k +: 4] = s[20 + 4*k +: 4] - 4'd3;
    end
    return s;
  endfunction

  // True when any digit of the packed operand lies outside 0..9.
  function automatic logic has_bad_digit(input logic [23:0] v);
    logic b;
    b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (v[4*k +: 4] > 4'd9)
        b = 1'b1;
    end
    return b;
  endfunction

  // Next-state and datapath update; everything holds unless a transition says otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bad_d   = bad_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    shifted = dabble_step(work_q);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          work_d  = {bus.bcd, 20'd0};
          cnt_d   = 5'd0;
          bad_d   = has_bad_digit(bus.bcd);
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          // Final shift: the low 20 bits now hold the binary result.
          bin_d   = bad_q ? 20'd0 : shifted[19:0];
          err_d   = bad_q;
          done_d  = 1'b1;
          cnt_d   = 5'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      work_q  <= 44'd0;
      bad_q   <= 1'b0;
      bin_q   <= 20'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bad_q   <= bad_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: hand-computed results, latency, busy width,
// error flagging, ignored mid-conversion start, reset abort and back-to-back mode.
module tb_bcd2bin_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bcd2bin_seq_if bus ();

  bcd2bin_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (from the negedge after the accepting edge) for done, counting edges
  // and busy cycles. Optionally injects a start/bcd poke at edge index poke_at.
  task automatic wait_done(input int poke_at, input logic [23:0] poke_v,
                           output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      if (n == poke_at) begin
        bus.start = 1'b1;
        bus.bcd   = poke_v;
      end else if (poke_at >= 0 && n == poke_at + 1) begin
        bus.start = 1'b0;
        bus.bcd   = 24'd0;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Single start pulse, then check latency, busy width, result and err.
  task automatic convert(input string tag, input logic [23:0] v, input logic [19:0] eb,
                         input logic ee, input int poke_at, input logic [23:0] poke_v);
    int n;
    int bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd   = 24'd0;
    wait_done(poke_at, poke_v, n, bc);
    check({tag, "_latency"}, n, 20);
    check({tag, "_busycyc"}, bc, 20);
    check({tag, "_bin"}, {12'd0, bus.bin}, {12'd0, eb});
    check({tag, "_err"}, {31'd0, bus.err}, {31'd0, ee});
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  // Counts done pulses over a window with start held low.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
  endtask

  initial begin
    int n;
    int bc;
    int pulses;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bcd   = 24'd0;
    repeat (3) @(negedge clk);
    check("rst_bin",  {12'd0, bus.bin}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err",  {31'd0, bus.err}, 32'd0);
    rst = 1'b0;

    convert("max",    24'h999999, 20'hF423F, 1'b0, -1, 24'd0);
    convert("mid",    24'h123456, 20'h1E240, 1'b0, -1, 24'd0);
    convert("zero",   24'h000000, 20'h00000, 1'b0, -1, 24'd0);
    convert("one",    24'h000001, 20'h00001, 1'b0, -1, 24'd0);
    convert("baddig", 24'h00A000, 20'h00000, 1'b1, -1, 24'd0);
    convert("ten",    24'h000010, 20'h0000A, 1'b0, -1, 24'd0);

    // Start while busy must be ignored and must not queue a second conversion.
    convert("ignore", 24'h000500, 20'h001F4, 1'b0, 4, 24'h000007);
    count_done(30, pulses);
    check("ignore_no_second_done", pulses, 0);
    check("ignore_bin_held", {12'd0, bus.bin}, 32'h001F4);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 24'h999999;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd   = 24'd0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bin",  {12'd0, bus.bin}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_err",  {31'd0, bus.err}, 32'd0);
    count_done(30, pulses);
    check("abort_no_done", pulses, 0);
    convert("after_rst", 24'h000042, 20'h0002A, 1'b0, -1, 24'd0);

    // Held start: one conversion per 21 clocks, busy low only in done cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 24'h065535;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wait_done(-1, 24'd0, n, bc);
      check($sformatf("b2b%0d_latency", k), n, 20);
      check($sformatf("b2b%0d_busycyc", k), bc, 20);
      check($sformatf("b2b%0d_bin", k), {12'd0, bus.bin}, 32'h0FFFF);
      check($sformatf("b2b%0d_err", k), {31'd0, bus.err}, 32'd0);
      check($sformatf("b2b%0d_busy_at_done", k), {31'd0, bus.busy}, 32'd0);
      if (k == 2) bus.start = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d_done_pulse", k), {31'd0, bus.done}, 32'd0);
      check($sformatf("b2b%0d_busy_next", k), {31'd0, bus.busy}, (k == 2) ? 32'd0 : 32'd1);
    end
    count_done(25, pulses);
    check("b2b_stopped", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
